// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage, two-entry skid buffer or single-entry pass-through
module pipe_stage_reg #(
  parameter int DATA_W = 13,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter bit SKID = 1'b1
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              Flush,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Data,
  output logic [1:0]        Count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state;
  logic [DATA_W-1:0] main_q, skid_q;
  logic in_xfer, out_xfer;
  assign Out_Valid = state != EMPTY;
  // skid mode decouples In_Ready from Out_Ready; single-entry mode forwards it
  assign In_Ready  = SKID ? state != TWO : !Out_Valid || Out_Ready;
  assign in_xfer   = In_Valid && In_Ready;
  assign out_xfer  = Out_Valid && Out_Ready;
  assign Out_Data  = main_q;
  assign Count     = state;
  always_ff @(posedge CLK or negedge CLR_N)
    if (!CLR_N) begin
      state  <= EMPTY;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else if (Flush) begin
      state  <= EMPTY;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else
      case (state)
        EMPTY: if (in_xfer) begin
          state  <= ONE;
          main_q <= In_Data;
        end
        ONE: if (in_xfer && out_xfer) main_q <= In_Data;
        else if (in_xfer) begin
          state  <= TWO;
          skid_q <= In_Data;
        end else if (out_xfer) begin
          state  <= EMPTY;
          main_q <= RST_VAL;
        end
        TWO: if (out_xfer) begin
          state  <= ONE;
          main_q <= skid_q;
          skid_q <= RST_VAL;
        end
        default: state <= EMPTY;
      endcase
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: both stage modes side by side against a queue model plus literal checkpoints
module tb_pipe_stage_reg;
  logic clk = 1'b0, clr_n, iv, fl, ordy;
  logic [12:0] id;
  logic ir1, ov1, ir0, ov0;
  logic [12:0] od1, od0;
  logic [1:0] c1, c0;
  int n_cmp = 0, n_bad = 0;
  logic [12:0] q1[$], q0[$];
  bit r1, r0, ox1, ox0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(13), .RST_VAL(13'h0), .SKID(1'b1)) dut1 (
    .CLK(clk), .CLR_N(clr_n), .In_Valid(iv), .In_Ready(ir1), .In_Data(id), .Flush(fl),
    .Out_Valid(ov1), .Out_Ready(ordy), .Out_Data(od1), .Count(c1));
  pipe_stage_reg #(.DATA_W(13), .RST_VAL(13'h0), .SKID(1'b0)) dut0 (
    .CLK(clk), .CLR_N(clr_n), .In_Valid(iv), .In_Ready(ir0), .In_Data(id), .Flush(fl),
    .Out_Valid(ov0), .Out_Ready(ordy), .Out_Data(od0), .Count(c0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clr_n) begin
    q1.delete();
    q0.delete();
  end

  always @(posedge clk) if (clr_n === 1'b1) begin
    r1  = q1.size() < 2;
    r0  = q0.size() == 0 || ordy;
    ox1 = q1.size() != 0 && ordy;
    ox0 = q0.size() != 0 && ordy;
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (ox1) void'(q1.pop_front());
      if (iv && r1) q1.push_back(id);
      if (ox0) void'(q0.pop_front());
      if (iv && r0) q0.push_back(id);
    end
  end

  always @(negedge clk) begin
    check("s1_valid", 32'(ov1), 32'(q1.size() != 0));
    check("s1_data", 32'(od1), 32'(q1.size() != 0 ? q1[0] : 13'h0));
    check("s1_count", 32'(c1), 32'(q1.size()));
    check("s1_ready", 32'(ir1), 32'(q1.size() < 2));
    check("s0_valid", 32'(ov0), 32'(q0.size() != 0));
    check("s0_data", 32'(od0), 32'(q0.size() != 0 ? q0[0] : 13'h0));
    check("s0_count", 32'(c0), 32'(q0.size()));
    check("s0_ready", 32'(ir0), 32'(q0.size() == 0 || ordy));
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    clr_n = 1'b0; iv = 1'b0; fl = 1'b0; ordy = 1'b0; id = '0;
    #1;
    check("rst_s1_ready", 32'(ir1), 32'd1);
    check("rst_s0_ready", 32'(ir0), 32'd1);
    check("rst_s1_count", 32'(c1), 32'd0);
    cyc(2);
    clr_n = 1'b1;
    ordy = 1'b1; iv = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      id = 13'(k);
      cyc();
      check("stream_s1_data", 32'(od1), 32'(k));
      check("stream_s0_data", 32'(od0), 32'(k));
      check("stream_s1_count", 32'(c1), 32'd1);
      check("stream_s1_ready", 32'(ir1), 32'd1);
    end
    iv = 1'b0;
    cyc();
    check("drain_s1_valid", 32'(ov1), 32'd0);
    ordy = 1'b0; iv = 1'b1; id = 13'h0A;
    cyc();
    check("s0_stall_ready", 32'(ir0), 32'd0);
    id = 13'h0B;
    cyc();
    check("stall_s1_count", 32'(c1), 32'd2);
    check("stall_s1_ready", 32'(ir1), 32'd0);
    check("stall_s1_data", 32'(od1), 32'h0A);
    check("stall_s0_count", 32'(c0), 32'd1);
    iv = 1'b0;
    cyc(3);
    check("hold_s1_data", 32'(od1), 32'h0A);
    ordy = 1'b1;
    #1;
    check("s0_unstall_ready", 32'(ir0), 32'd1);
    cyc();
    check("unstall_s1_data", 32'(od1), 32'h0B);
    check("unstall_s1_count", 32'(c1), 32'd1);
    cyc();
    check("empty_s1_count", 32'(c1), 32'd0);
    ordy = 1'b0; iv = 1'b1; id = 13'h11;
    cyc();
    id = 13'h12;
    cyc();
    check("preflush_s1_count", 32'(c1), 32'd2);
    fl = 1'b1; id = 13'h1F;
    cyc();
    fl = 1'b0; iv = 1'b0;
    check("flush_s1_count", 32'(c1), 32'd0);
    check("flush_s1_valid", 32'(ov1), 32'd0);
    check("flush_s1_data", 32'(od1), 32'd0);
    ordy = 1'b1;
    cyc(2);
    check("flush_no_1f", 32'(ov1), 32'd0);
    ordy = 1'b0; iv = 1'b1; id = 13'h05;
    cyc();
    id = 13'h06;
    cyc();
    iv = 1'b0;
    check("prerst_s1_count", 32'(c1), 32'd2);
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    check("arst_s1_valid", 32'(ov1), 32'd0);
    check("arst_s1_data", 32'(od1), 32'd0);
    check("arst_s1_count", 32'(c1), 32'd0);
    iv = 1'b1; id = 13'h07;
    cyc();
    check("rst_nostore", 32'(c1), 32'd0);
    clr_n = 1'b1; id = 13'h33;
    cyc();
    iv = 1'b0;
    check("post_rst_s1_data", 32'(od1), 32'h33);
    check("post_rst_s0_data", 32'(od0), 32'h33);
    for (int k = 0; k < 10000; k++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      fl   = $urandom_range(0, 49) == 0;
      id   = 13'($urandom);
      cyc();
      if (c1 > 2'd2 || c0 > 2'd1) check("count_bound", 32'(c1), 32'(q1.size()));
    end
    fl = 1'b0; iv = 1'b0;
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
